// File: rtl/dma_controller.sv
// DMA sequencer: moves CHUNK_WORDS-word device chunks into memory, one write per chunk.
// Optional macro DMA_CYCLE_STEAL_EN releases the bus for one cycle between chunks; default is burst mode.
module dma_controller #(
    parameter int WORD_SIZE   = 16,
    parameter int CHUNK_WORDS = 4,
    parameter int NUM_CHUNKS  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dev_interrupt,
    input  logic                 cmd_valid,
    input  logic [WORD_SIZE-1:0] cmd_addr,
    input  logic [WORD_SIZE-1:0] cmd_length,
    input  logic                 bus_grant,
    input  logic                 mem_ready,
    output logic                 bus_request,
    output logic [1:0]           dev_offset,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 mem_write,
    output logic                 dma_begin,
    output logic                 dma_end,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CMD = 3'd1,
        REQ      = 3'd2,
        SETUP    = 3'd3,
        WRITE    = 3'd4,
        DONE     = 3'd5,
        RELEASE  = 3'd6
    } state_t;

    state_t               state, state_next;
    logic [WORD_SIZE-1:0] base;
    logic [WORD_SIZE-1:0] len_chunks;
    logic [1:0]           chunk, nchunks, nchunks_cmd;
    logic                 int_prev, pend, begin_q;
    logic                 int_rise, start, last_chunk, accept;

    assign int_rise   = dev_interrupt && !int_prev;
    assign start      = int_rise || pend;
    assign last_chunk = (chunk == nchunks - 2'd1);
    assign accept     = (state == WRITE) && bus_grant && mem_ready;

    // Chunk count is the rounded-up word count, clamped to the device storage depth.
    always_comb begin
        len_chunks = cmd_length / WORD_SIZE'(CHUNK_WORDS);
        if ((cmd_length % WORD_SIZE'(CHUNK_WORDS)) != '0)
            len_chunks = len_chunks + WORD_SIZE'(1);
        nchunks_cmd = (len_chunks >= WORD_SIZE'(NUM_CHUNKS)) ? 2'(NUM_CHUNKS) : len_chunks[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            chunk    <= '0;
            nchunks  <= '0;
            int_prev <= 1'b0;
            pend     <= 1'b0;
            begin_q  <= 1'b0;
        end else begin
            state    <= state_next;
            int_prev <= dev_interrupt;
            begin_q  <= (state == IDLE) && start;
            if ((state == IDLE) && start)
                pend <= 1'b0;
            else if ((state != IDLE) && int_rise)
                pend <= 1'b1;
            if ((state == WAIT_CMD) && cmd_valid) begin
                base    <= cmd_addr;
                nchunks <= nchunks_cmd;
            end
            if (accept)
                chunk <= chunk + 2'd1;
            else if (state == DONE)
                chunk <= '0;
        end
    end

    // A dropped grant simply freezes SETUP/WRITE; the same chunk resumes on regrant.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = WAIT_CMD;
            WAIT_CMD: if (cmd_valid) state_next = (nchunks_cmd == 2'd0) ? DONE : REQ;
            REQ:      if (bus_grant) state_next = SETUP;
            SETUP:    if (bus_grant) state_next = WRITE;
            WRITE: begin
                if (accept) begin
                    if (last_chunk)
                        state_next = DONE;
                    else begin
`ifdef DMA_CYCLE_STEAL_EN
                        state_next = RELEASE;
`else
                        state_next = SETUP;
`endif
                    end
                end
            end
            DONE:     state_next = IDLE;
            RELEASE:  state_next = REQ;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_request = (state == REQ) || (state == SETUP) || (state == WRITE);
        dev_offset  = 2'b11;
        mem_addr    = '0;
        if ((state == SETUP) || (state == WRITE)) begin
            dev_offset = chunk;
            mem_addr   = base + WORD_SIZE'(chunk) * WORD_SIZE'(CHUNK_WORDS);
        end
        mem_write = (state == WRITE) && bus_grant;
        dma_begin = begin_q;
        dma_end   = (state == DONE);
        busy      = (state != IDLE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: responder grants 2 cycles after BR, mem_ready 1 cycle after mem_write.
// Accepted writes are scored against hand-computed {offset, address} expectations.
module tb_dma_controller;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, dev_interrupt, cmd_valid, bus_grant, mem_ready;
    logic [W-1:0] cmd_addr, cmd_length, mem_addr;
    logic         bus_request, mem_write, dma_begin, dma_end, busy;
    logic [1:0]   dev_offset;
    logic [2:0]   state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    dma_controller dut (
        .clk(clk), .reset(reset), .dev_interrupt(dev_interrupt), .cmd_valid(cmd_valid),
        .cmd_addr(cmd_addr), .cmd_length(cmd_length), .bus_grant(bus_grant), .mem_ready(mem_ready),
        .bus_request(bus_request), .dev_offset(dev_offset), .mem_addr(mem_addr),
        .mem_write(mem_write), .dma_begin(dma_begin), .dma_end(dma_end), .busy(busy),
        .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer: interrupt, command, then a cycle-by-cycle bus/memory responder.
    task automatic run_xfer(input string tag, input logic [15:0] addr, input logic [15:0] len,
                            input int exp_n, input int drop_chunk, input int pend_at);
        int cyc = 0, g_cyc = -1, w_cyc = -1, br_low = 0, drop_left = 0, bad_mw = 0, n_wr = 0;
        int exp_low;
        logic br_seen = 1'b0, dropped = 1'b0, mw_prev = 1'b0, done = 1'b0;
        logic [1:0] hist = 2'b00;
        logic [17:0] e;

        dev_interrupt = 1'b1;
        step();
        check({tag, ".begin"}, dma_begin, 1);
        check({tag, ".busy"}, busy, 1);
        dev_interrupt = 1'b0;
        step();
        check({tag, ".begin_width"}, dma_begin, 0);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_length = len;
        step();
        cmd_valid = 1'b0;

        while (!done && cyc < 80) begin
            if (dma_end) begin
                done = 1'b1;
                bus_grant = 1'b0;
                mem_ready = 1'b0;
                check({tag, ".end_br"}, bus_request, 0);
                check({tag, ".end_offset"}, dev_offset, 2'b11);
            end else begin
                dev_interrupt = (cyc == pend_at);
                if (bus_request) br_seen = 1'b1;
                else if (br_seen) br_low++;
                if (drop_left > 0) begin
                    bus_grant = 1'b0;
                    drop_left--;
                end else begin
                    bus_grant = bus_request && (hist == 2'b11);
                end
                if (bus_grant && g_cyc < 0) g_cyc = cyc;
                hist = {hist[0], bus_request};
                #1;
                if (!bus_grant && mem_write) bad_mw++;
                if (mem_write && w_cyc < 0) w_cyc = cyc;
                mem_ready = mem_write && mw_prev;
                if (mem_write && !dropped && drop_chunk == int'(dev_offset)) begin
                    dropped = 1'b1;
                    drop_left = 3;
                end
                if (mem_write && mem_ready) begin
                    n_wr++;
                    if (exp_q.size() == 0) begin
                        check({tag, ".extra_write"}, n_wr, exp_n);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, ".write"}, {dev_offset, mem_addr}, e);
                    end
                end
                mw_prev = mem_write;
                step();
                cyc++;
            end
        end
        dev_interrupt = 1'b0;

        check({tag, ".end_seen"}, done, 1);
        check({tag, ".write_count"}, n_wr, exp_n);
        check({tag, ".br_seen"}, br_seen, (exp_n > 0));
        check({tag, ".mw_without_bg"}, bad_mw, 0);
`ifdef DMA_CYCLE_STEAL_EN
        exp_low = (exp_n > 0) ? exp_n - 1 : 0;
`else
        exp_low = 0;
`endif
        check({tag, ".br_low_cycles"}, br_low, exp_low);
        if (exp_n > 0) check({tag, ".bg_to_write"}, w_cyc - g_cyc, 2);
    endtask

    initial begin
        int cyc;
        logic seen_end;

        reset = 1'b1; dev_interrupt = 1'b0; cmd_valid = 1'b0; bus_grant = 1'b0; mem_ready = 1'b0;
        cmd_addr = '0; cmd_length = '0;
        repeat (3) step();
        check("rst.bus_request", bus_request, 0);
        check("rst.dev_offset", dev_offset, 2'b11);
        check("rst.mem_addr", mem_addr, 16'h0000);
        check("rst.mem_write", mem_write, 0);
        check("rst.dma_begin", dma_begin, 0);
        check("rst.dma_end", dma_end, 0);
        check("rst.busy", busy, 0);
        reset = 1'b0;
        step();

        exp_q.delete();
        exp_q.push_back({2'd0, 16'h0100}); exp_q.push_back({2'd1, 16'h0104}); exp_q.push_back({2'd2, 16'h0108});
        run_xfer("len12", 16'h0100, 16'd12, 3, -1, -1);
        step();

        exp_q.delete();
        exp_q.push_back({2'd0, 16'h0100}); exp_q.push_back({2'd1, 16'h0104});
        run_xfer("len5", 16'h0100, 16'd5, 2, -1, -1);
        step();

        exp_q.delete();
        exp_q.push_back({2'd0, 16'h0200}); exp_q.push_back({2'd1, 16'h0204}); exp_q.push_back({2'd2, 16'h0208});
        run_xfer("len40", 16'h0200, 16'd40, 3, -1, -1);
        step();

        exp_q.delete();
        run_xfer("len0", 16'h0300, 16'd0, 0, -1, -1);
        step();

        exp_q.delete();
        exp_q.push_back({2'd0, 16'h0100}); exp_q.push_back({2'd1, 16'h0104}); exp_q.push_back({2'd2, 16'h0108});
        run_xfer("bgdrop", 16'h0100, 16'd12, 3, 1, -1);
        step();

        exp_q.delete();
        exp_q.push_back({2'd0, 16'hFFFC}); exp_q.push_back({2'd1, 16'h0000});
        run_xfer("wrap", 16'hFFFC, 16'd8, 2, -1, -1);
        step();

        // Second interrupt while busy: serviced from IDLE right after DONE.
        exp_q.delete();
        exp_q.push_back({2'd0, 16'h0100});
        run_xfer("pend", 16'h0100, 16'd4, 1, -1, 2);
        step();
        check("pend.idle_begin", dma_begin, 0);
        check("pend.idle_busy", busy, 0);
        step();
        check("pend.second_begin", dma_begin, 1);
        check("pend.second_busy", busy, 1);
        cmd_valid = 1'b1; cmd_addr = 16'h0400; cmd_length = 16'd0;
        step();
        cmd_valid = 1'b0;
        check("pend.zero_end", dma_end, 1);
        step();
        check("pend.back_idle", busy, 0);

        // Reset during WRITE aborts immediately with no dma_end.
        dev_interrupt = 1'b1; step(); dev_interrupt = 1'b0; step();
        cmd_valid = 1'b1; cmd_addr = 16'h0500; cmd_length = 16'd8;
        step();
        cmd_valid = 1'b0; bus_grant = 1'b1; mem_ready = 1'b0;
        cyc = 0;
        while (!mem_write && cyc < 20) begin
            step();
            cyc++;
        end
        check("rstmid.reached_write", mem_write, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid.bus_request", bus_request, 0);
        check("rstmid.mem_write", mem_write, 0);
        check("rstmid.dev_offset", dev_offset, 2'b11);
        check("rstmid.mem_addr", mem_addr, 16'h0000);
        check("rstmid.busy", busy, 0);
        check("rstmid.dma_end", dma_end, 0);
        bus_grant = 1'b0;
        seen_end = 1'b0;
        repeat (5) begin
            step();
            if (dma_end) seen_end = 1'b1;
        end
        check("rstmid.no_end", seen_end, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
